// File: rtl/atm_pkg.sv
// ATM shared definitions: op codes, session FSM states, default widths.
package atm_pkg;

   localparam int BAL_W = 20;

   localparam logic [1:0] OP_INQ  = 2'b00;
   localparam logic [1:0] OP_DEP  = 2'b01;
   localparam logic [1:0] OP_WDR  = 2'b10;
   localparam logic [1:0] OP_EXIT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIN_WAIT,
      S_PIN_CHECK,
      S_PIN_RETRY,
      S_MENU,
      S_EXEC,
      S_EJECT
   } state_e;

endpackage

// File: rtl/session_timer.sv
// Loadable down-counter; expire_o flags the last counting cycle.
module session_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         load_i,
   input  logic         en_i,
   input  logic [W-1:0] load_val_i,
   output logic         expire_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == W'(1));

endmodule

// File: rtl/transaction_ctrl.sv
// ATM session controller: PIN retry, menu and balance ops.
// WITHDRAW_LIMIT_EN adds a per-session withdraw cap (session_limit).
module transaction_ctrl
   import atm_pkg::*;
#(
   parameter int balance_width  = BAL_W,
   parameter int max_tries      = 3,
   parameter int timeout_cycles = 1000,
   parameter int tmr_width      = 10
`ifdef WITHDRAW_LIMIT_EN
   ,
   parameter int session_limit  = 5000
`endif
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     card_in,
   input  logic                     pin_valid,
   input  logic                     wrong_psw,
   input  logic [balance_width-1:0] balance,
   input  logic                     op_valid,
   input  logic [1:0]               op_code,
   input  logic [balance_width-1:0] amount,
   output logic                     op_ready,
   output logic                     op_done,
   output logic                     op_err,
   output logic [balance_width-1:0] updated_balance,
   output logic                     card_out,
   output logic                     locked
);

   localparam int TRW = $clog2(max_tries + 1);
   localparam logic [TRW-1:0] TRIES_MAX = TRW'(max_tries);
   localparam logic [tmr_width-1:0] TMR_LOAD = tmr_width'(timeout_cycles);

   state_e                   state_q, state_d;
   logic [TRW-1:0]           tries_q, tries_d, tries_inc;
   logic [balance_width-1:0] bal_q, bal_d;
   logic [balance_width-1:0] amt_q, amt_d;
   logic [1:0]               op_q, op_d;
   logic                     card_q;
   logic                     done_q, done_d;
   logic                     err_q, err_d;
   logic                     lock_q, lock_d;
   logic [balance_width:0]   dep_sum;
   logic                     card_rise, in_session;
   logic                     tmr_en, tmr_load, tmr_exp, timeout;
   logic                     wdr_ok;

`ifdef WITHDRAW_LIMIT_EN
   localparam logic [balance_width:0] LIMIT =
      (balance_width + 1)'(session_limit);
   logic [balance_width-1:0] acc_q, acc_d;
   logic [balance_width:0]   acc_sum;

   assign acc_sum = {1'b0, acc_q} + {1'b0, amt_q};
   assign wdr_ok  = (amt_q <= bal_q) && (acc_sum <= LIMIT);
`else
   assign wdr_ok  = (amt_q <= bal_q);
`endif

   assign card_rise  = card_in & ~card_q;
   assign in_session = (state_q != S_IDLE) && (state_q != S_EJECT);
   assign tries_inc  = tries_q + TRW'(1);
   assign dep_sum    = {1'b0, bal_q} + {1'b0, amt_q};
   assign tmr_en     = (state_q == S_MENU) || (state_q == S_PIN_RETRY);
   assign tmr_load   = (state_d != state_q) || op_valid || pin_valid;
   // A strobe on the expiry cycle keeps the session alive.
   assign timeout    = tmr_exp && !op_valid && !pin_valid;

   session_timer #(
      .W(tmr_width)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (state_q == S_IDLE),
      .load_i    (tmr_load),
      .en_i      (tmr_en),
      .load_val_i(TMR_LOAD),
      .expire_o  (tmr_exp)
   );

   always_comb begin
      state_d = state_q;
      tries_d = tries_q;
      bal_d   = bal_q;
      amt_d   = amt_q;
      op_d    = op_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      lock_d  = 1'b0;
`ifdef WITHDRAW_LIMIT_EN
      acc_d   = acc_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (card_rise) state_d = S_PIN_WAIT;
         end
         S_PIN_WAIT: begin
            state_d = S_PIN_CHECK;
         end
         S_PIN_CHECK: begin
            if (!wrong_psw) begin
               bal_d   = balance;
               tries_d = '0;
               state_d = S_MENU;
            end else begin
               tries_d = tries_inc;
               if (tries_inc == TRIES_MAX) begin
                  lock_d  = 1'b1;
                  state_d = S_EJECT;
               end else begin
                  state_d = S_PIN_RETRY;
               end
            end
         end
         S_PIN_RETRY: begin
            if (pin_valid)    state_d = S_PIN_WAIT;
            else if (timeout) state_d = S_EJECT;
         end
         S_MENU: begin
            if (op_valid) begin
               op_d    = op_code;
               amt_d   = amount;
               state_d = S_EXEC;
            end else if (timeout) begin
               state_d = S_EJECT;
            end
         end
         S_EXEC: begin
            state_d = S_MENU;
            unique case (op_q)
               OP_INQ: done_d = 1'b1;
               OP_DEP: begin
                  if (dep_sum[balance_width]) begin
                     err_d = 1'b1;
                  end else begin
                     bal_d  = dep_sum[balance_width-1:0];
                     done_d = 1'b1;
                  end
               end
               OP_WDR: begin
                  if (!wdr_ok) begin
                     err_d = 1'b1;
                  end else begin
                     bal_d  = bal_q - amt_q;
                     done_d = 1'b1;
`ifdef WITHDRAW_LIMIT_EN
                     acc_d  = acc_q + amt_q;
`endif
                  end
               end
               default: state_d = S_EJECT;
            endcase
         end
         S_EJECT: begin
            if (!card_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Pulling the card aborts whatever the session was doing.
      if (in_session && !card_in) begin
         state_d = S_EJECT;
         tries_d = tries_q;
         bal_d   = bal_q;
         done_d  = 1'b0;
         err_d   = 1'b0;
         lock_d  = 1'b0;
`ifdef WITHDRAW_LIMIT_EN
         acc_d   = acc_q;
`endif
      end

      if (state_d == S_IDLE) begin
         tries_d = '0;
         bal_d   = '0;
`ifdef WITHDRAW_LIMIT_EN
         acc_d   = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         tries_q <= '0;
         bal_q   <= '0;
         amt_q   <= '0;
         op_q    <= OP_INQ;
         card_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tries_q <= tries_d;
         bal_q   <= bal_d;
         amt_q   <= amt_d;
         op_q    <= op_d;
         card_q  <= card_in;
         done_q  <= done_d;
         err_q   <= err_d;
         lock_q  <= lock_d;
      end
   end

`ifdef WITHDRAW_LIMIT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   assign op_ready        = (state_q == S_MENU);
   assign card_out        = (state_q == S_EJECT);
   assign updated_balance = bal_q;
   assign op_done         = done_q;
   assign op_err          = err_q;
   assign locked          = lock_q;

endmodule

// File: tb/tb_transaction_ctrl.sv
// Directed + randomized bench for transaction_ctrl against a session model.
module tb_transaction_ctrl;

   localparam int W  = 20;
   localparam int MT = 3;
   localparam int TO = 64;
   localparam int TW = 10;
   localparam longint MAXB = (longint'(1) << W) - 1;
`ifdef WITHDRAW_LIMIT_EN
   localparam longint LIM = 500;
`endif

   localparam int M_IDLE  = 0;
   localparam int M_WAIT  = 1;
   localparam int M_CHECK = 2;
   localparam int M_RETRY = 3;
   localparam int M_MENU  = 4;
   localparam int M_EXEC  = 5;
   localparam int M_EJECT = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         card_in = 1'b0;
   logic         pin_valid = 1'b0;
   logic         wrong_psw = 1'b0;
   logic [W-1:0] balance = '0;
   logic         op_valid = 1'b0;
   logic [1:0]   op_code = 2'b00;
   logic [W-1:0] amount = '0;
   logic         op_ready, op_done, op_err;
   logic         card_out, locked;
   logic [W-1:0] updated_balance;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   transaction_ctrl #(
      .balance_width (W),
      .max_tries     (MT),
      .timeout_cycles(TO),
      .tmr_width     (TW)
`ifdef WITHDRAW_LIMIT_EN
      ,
      .session_limit (500)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .card_in        (card_in),
      .pin_valid      (pin_valid),
      .wrong_psw      (wrong_psw),
      .balance        (balance),
      .op_valid       (op_valid),
      .op_code        (op_code),
      .amount         (amount),
      .op_ready       (op_ready),
      .op_done        (op_done),
      .op_err         (op_err),
      .updated_balance(updated_balance),
      .card_out       (card_out),
      .locked         (locked)
   );

   // ---------------- behavioural session model ----------------
   int     m_mode  = M_IDLE;
   int     m_idle  = 0;
   int     m_tries = 0;
   int     m_op    = 0;
   longint m_bal   = 0;
   longint m_acc   = 0;
   longint m_amt   = 0;
   bit     m_prev  = 0;
   bit     m_done  = 0;
   bit     m_err   = 0;
   bit     m_lock  = 0;

   function automatic bit over_limit(input longint amt);
`ifdef WITHDRAW_LIMIT_EN
      return (m_acc + amt) > LIM;
`else
      return amt < 0;
`endif
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_idle  = 0;
      m_tries = 0;
      m_bal   = 0;
      m_acc   = 0;
      m_prev  = 0;
      m_done  = 0;
      m_err   = 0;
      m_lock  = 0;
   endtask

   task automatic model_step();
      int nx;
      bit strobe;
      nx     = m_mode;
      m_done = 0;
      m_err  = 0;
      m_lock = 0;
      strobe = op_valid || pin_valid;
      if (m_mode != M_IDLE && m_mode != M_EJECT && !card_in) begin
         nx = M_EJECT;
      end else begin
         case (m_mode)
            M_IDLE:  if (card_in && !m_prev) nx = M_WAIT;
            M_WAIT:  nx = M_CHECK;
            M_CHECK: begin
               if (!wrong_psw) begin
                  m_bal   = balance;
                  m_tries = 0;
                  nx      = M_MENU;
               end else begin
                  m_tries++;
                  m_lock = (m_tries == MT);
                  nx     = m_lock ? M_EJECT : M_RETRY;
               end
            end
            M_RETRY: begin
               if (pin_valid) nx = M_WAIT;
               else if (!strobe && m_idle + 1 >= TO) nx = M_EJECT;
            end
            M_MENU: begin
               if (op_valid) begin
                  m_op  = op_code;
                  m_amt = amount;
                  nx    = M_EXEC;
               end else if (!strobe && m_idle + 1 >= TO) begin
                  nx = M_EJECT;
               end
            end
            M_EXEC: begin
               nx = M_MENU;
               case (m_op)
                  0: m_done = 1;
                  1: begin
                     if (m_bal + m_amt > MAXB) m_err = 1;
                     else begin
                        m_bal  = m_bal + m_amt;
                        m_done = 1;
                     end
                  end
                  2: begin
                     if (m_amt > m_bal || over_limit(m_amt)) m_err = 1;
                     else begin
                        m_bal  = m_bal - m_amt;
                        m_acc  = m_acc + m_amt;
                        m_done = 1;
                     end
                  end
                  default: nx = M_EJECT;
               endcase
            end
            M_EJECT: if (!card_in) nx = M_IDLE;
            default: nx = M_IDLE;
         endcase
      end
      if (nx != m_mode || strobe) m_idle = 0;
      else if (m_mode == M_MENU || m_mode == M_RETRY) m_idle++;
      if (nx == M_IDLE) begin
         m_bal   = 0;
         m_tries = 0;
         m_acc   = 0;
      end
      m_mode = nx;
      m_prev = card_in;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string nm, input longint act,
                        input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         check("op_ready", op_ready, m_mode == M_MENU);
         check("card_out", card_out, m_mode == M_EJECT);
         check("op_done", op_done, m_done);
         check("op_err", op_err, m_err);
         check("locked", locked, m_lock);
         check("updated_balance", updated_balance, m_bal);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic insert(input longint bal, input bit wrong);
      card_in   = 1'b1;
      balance   = bal[W-1:0];
      wrong_psw = wrong;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_op(input logic [1:0] code, input longint amt);
      op_valid = 1'b1;
      op_code  = code;
      amount   = amt[W-1:0];
      @(negedge clk);
      op_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic pin(input bit wrong);
      wrong_psw = wrong;
      pin_valid = 1'b1;
      @(negedge clk);
      pin_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic leave();
      do_op(2'b11, 0);
      check("exit_card_out", card_out, 1);
      check("exit_no_done", op_done, 0);
      card_in = 1'b0;
      repeat (2) @(negedge clk);
      check("exit_idle_card_out", card_out, 0);
   endtask

   function automatic longint pick_amount();
      int r;
      r = $urandom_range(0, 6);
      case (r)
         0:       return 0;
         1:       return m_bal;
         2:       return m_bal + 1;
         3:       return MAXB - m_bal + $urandom_range(0, 1);
         4:       return $urandom_range(0, 2000);
         default: return $urandom_range(0, 32'(MAXB));
      endcase
   endfunction

   function automatic longint pick_balance();
      int r;
      r = $urandom_range(0, 3);
      case (r)
         0:       return MAXB - $urandom_range(0, 20);
         1:       return $urandom_range(0, 3000);
         default: return $urandom_range(0, 32'(MAXB));
      endcase
   endfunction

   initial begin
      bit quiet;
      int r;
      longint v;
      quiet = 0;

      #1;
      check("rst_ready", op_ready, 0);
      check("rst_card_out", card_out, 0);
      check("rst_balance", updated_balance, 0);
      check("rst_done", op_done, 0);
      check("rst_err", op_err, 0);
      check("rst_locked", locked, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // login and withdraw sequence
      insert(1000, 0);
      check("t1_ready", op_ready, 1);
      check("t1_balance", updated_balance, 1000);
      do_op(2'b10, 400);
      check("t3_wdr400_done", op_done, 1);
      check("t3_wdr400_bal", updated_balance, 600);
      do_op(2'b10, 700);
      check("t3_wdr700_err", op_err, 1);
      check("t3_wdr700_done", op_done, 0);
      check("t3_wdr700_bal", updated_balance, 600);
      do_op(2'b10, 600);
      check("t3_wdr600_done", op_done, 1);
      check("t3_wdr600_bal", updated_balance, 0);
      do_op(2'b01, 0);
      check("t3_dep0_done", op_done, 1);
      leave();

      // deposit overflow boundary
      insert(MAXB - 9, 0);
      do_op(2'b01, 10);
      check("t4_dep10_err", op_err, 1);
      check("t4_dep10_bal", updated_balance, MAXB - 9);
      do_op(2'b01, 9);
      check("t4_dep9_done", op_done, 1);
      check("t4_dep9_bal", updated_balance, MAXB);
      leave();

      // three wrong PINs
      insert(0, 1);
      check("t2_retry_ready", op_ready, 0);
      pin(1);
      check("t2_second_locked", locked, 0);
      pin(1);
      check("t2_third_locked", locked, 1);
      check("t2_third_card_out", card_out, 1);
      @(negedge clk);
      check("t2_lock_pulse_end", locked, 0);
      card_in = 1'b0;
      @(negedge clk);
      check("t2_idle_card_out", card_out, 0);

      // timeout in MENU
      insert(500, 0);
      repeat (TO - 1) @(negedge clk);
      check("t5_before_expiry", card_out, 0);
      @(negedge clk);
      check("t5_expired", card_out, 1);
      card_in = 1'b0;
      @(negedge clk);
      insert(500, 0);
      repeat (TO - 1) @(negedge clk);
      do_op(2'b00, 0);
      check("t5_strobe_wins_done", op_done, 1);
      check("t5_strobe_wins_card", card_out, 0);

      // reset during EXEC
      op_valid = 1'b1;
      op_code  = 2'b01;
      amount   = 20'd7;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("t6_rst_balance", updated_balance, 0);
      check("t6_rst_done", op_done, 0);
      check("t6_rst_card_out", card_out, 0);
      check("t6_rst_ready", op_ready, 0);
      op_valid = 1'b0;
      card_in  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("t6_no_done", op_done, 0);

      // session withdraw cap
      insert(1000, 0);
      do_op(2'b10, 300);
      check("lim_first_done", op_done, 1);
      do_op(2'b10, 300);
`ifdef WITHDRAW_LIMIT_EN
      check("lim_second_err", op_err, 1);
      check("lim_second_bal", updated_balance, 700);
`else
      check("lim_second_done", op_done, 1);
      check("lim_second_bal", updated_balance, 400);
`endif
      leave();

      // randomized traffic
      for (int c = 0; c < 8000; c++) begin
         if (c % 300 == 0) quiet = ($urandom_range(0, 2) == 0);
         if (m_mode == M_EJECT)
            card_in = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
         else if (!card_in)
            card_in = ($urandom_range(0, 4) == 0);
         else if ($urandom_range(0, 299) == 0)
            card_in = 1'b0;
         wrong_psw = ($urandom_range(0, 2) == 0);
         v = pick_balance();
         balance = v[W-1:0];
         pin_valid = !quiet && ($urandom_range(0, 5) == 0);
         op_valid  = !quiet && ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 9);
         op_code = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 :
                   (r < 9) ? 2'b10 : 2'b11;
         v = pick_amount();
         amount = v[W-1:0];
         @(negedge clk);
      end
      op_valid  = 1'b0;
      pin_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
